// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU request sequencer: op encodings, FSM state type
// and the default datapath width.
package alu_seq_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StExec,
    StResp
  } alu_seq_state_t;

  // CMP runs the ALU as a subtract; only the returned data differs.
  function automatic logic op_is_sub(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/flag_reg.sv
// Two-bit carry/zero flags register with async active-low clear and load enable.
module flag_reg (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       load,
  input  logic [1:0] flags_in,
  output logic [1:0] flags
);

  logic [1:0] flags_d, flags_q;

  always_comb begin
    flags_d = flags_q;
    if (load) flags_d = flags_in;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags = flags_q;

endmodule

// File: rtl/alu_seq.sv
// ALU request sequencer: accepts ops over valid/ready, drives the ALU through a
// setup/enable sequence, captures result and flags, returns them over valid/ready.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cf,
  output logic             rsp_zf,
  output logic             rsp_err,
  output logic             flag_c,
  output logic             flag_z,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_sub,
  output logic             alu_sumout,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cf,
  input  logic             alu_zf
);

  alu_seq_state_t state_d, state_q;

  logic [1:0]       op_d, op_q;
  logic [WIDTH-1:0] a_d, a_q;
  logic [WIDTH-1:0] b_d, b_q;
  logic [WIDTH-1:0] rsp_data_d, rsp_data_q;
  logic             rsp_cf_d, rsp_cf_q;
  logic             rsp_zf_d, rsp_zf_q;
  logic             rsp_err_d, rsp_err_q;
  logic             accept;
  logic             busy;
  logic             flag_load;
  logic [1:0]       flags;

  // State register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = (req_op == OP_ILL) ? StResp : StSetup;
      StSetup: state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state; alu_sumout falls with the async reset.
  always_comb begin
    req_ready  = (state_q == StIdle);
    rsp_valid  = (state_q == StResp);
    busy       = (state_q == StSetup) || (state_q == StExec);
    accept     = req_ready && req_valid;
    flag_load  = (state_q == StExec);
    alu_sumout = (state_q == StExec);
    alu_a      = busy ? a_q : '0;
    alu_b      = busy ? b_q : '0;
    alu_sub    = busy && op_is_sub(op_q);
  end

  always_comb begin
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    rsp_cf_d   = rsp_cf_q;
    rsp_zf_d   = rsp_zf_q;
    rsp_err_d  = rsp_err_q;
    if (accept) begin
      op_d = req_op;
      a_d  = req_a;
      b_d  = req_b;
      if (req_op == OP_ILL) begin
        rsp_data_d = '0;
        rsp_cf_d   = 1'b0;
        rsp_zf_d   = 1'b0;
        rsp_err_d  = 1'b1;
      end
    end
    if (state_q == StExec) begin
      rsp_data_d = (op_q == OP_CMP) ? a_q : alu_out;
      rsp_cf_d   = alu_cf;
      rsp_zf_d   = alu_zf;
      rsp_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_cf_q   <= 1'b0;
      rsp_zf_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      rsp_cf_q   <= rsp_cf_d;
      rsp_zf_q   <= rsp_zf_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_cf   = rsp_cf_q;
  assign rsp_zf   = rsp_zf_q;
  assign rsp_err  = rsp_err_q;

  flag_reg u_flag_reg (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (flag_load),
    .flags_in ({alu_cf, alu_zf}),
    .flags    (flags)
  );

  assign flag_c = flags[1];
  assign flag_z = flags[0];

endmodule
